// File: rtl/toy_trace_capture.sv
// toy_trace_capture
// Passive observer of the Toy CPU core.
// - Samples pc/A/T on every clock edge while trace_en is high.
// - Logs one {pc, A, T} record into a first-word-fall-through FIFO each time the PC changes.
// - Raises a sticky halted flag when the PC stays unchanged for HALT_CYCLES enabled edges.
// A host drains the records through a valid/ready read port.
// Optional feature (macro TOY_TRACE_TSTAMP_EN): each record also stores a TS_W-bit
// free-running cycle stamp, taken at the sampling edge.
// Without the macro, rd_tstamp is tied to zero.
module toy_trace_capture #(
   parameter int DEPTH       = 16,
   parameter int HALT_CYCLES = 8,
   parameter int TS_W        = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [11:0]              pc_in,
   input  logic [15:0]              reg_a_in,
   input  logic [15:0]              reg_t_in,
   input  logic                     trace_en,
   input  logic                     rd_ready,
   output logic                     rd_valid,
   output logic [11:0]              rd_pc,
   output logic [15:0]              rd_a,
   output logic [15:0]              rd_t,
   output logic [TS_W-1:0]          rd_tstamp,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [7:0]               drop_cnt,
   output logic                     halted
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(HALT_CYCLES + 1);
   localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);
   localparam logic [SW-1:0] HALT_LIMIT = SW'(HALT_CYCLES);

   logic [11:0]   pc_mem [DEPTH];
   logic [15:0]   a_mem  [DEPTH];
   logic [15:0]   t_mem  [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   logic [11:0]   last_pc;
   logic          last_pc_vld;
   logic [SW-1:0] stuck_cnt;
   logic [SW-1:0] stuck_nxt;

   logic          pc_same;
   logic          push_req;
   logic          push_ok;
   logic          push_drop;
   logic          pop;

   // Record request and FIFO handshake decisions for the current edge
   always_comb begin
      pc_same   = last_pc_vld && (pc_in == last_pc);
      push_req  = trace_en && !pc_same;
      rd_valid  = (level != '0);
      pop       = rd_valid && rd_ready;
      push_ok   = push_req && ((level != FULL_LEVEL) || pop);
      push_drop = push_req && !push_ok;
   end

   // Stuck-PC counter: counts enabled repeat edges, clears on change, holds while disabled
   always_comb begin
      stuck_nxt = stuck_cnt;
      if (trace_en) begin
         if (pc_same) begin
            if (stuck_cnt != HALT_LIMIT) begin
               stuck_nxt = stuck_cnt + 1'b1;
            end
         end else begin
            stuck_nxt = '0;
         end
      end
   end

   // Last-PC tracker, stuck counter and sticky halt flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_pc     <= '0;
         last_pc_vld <= 1'b0;
         stuck_cnt   <= '0;
         halted      <= 1'b0;
      end else begin
         stuck_cnt <= stuck_nxt;
         if (stuck_nxt == HALT_LIMIT) begin
            halted <= 1'b1;
         end
         if (trace_en) begin
            last_pc     <= pc_in;
            last_pc_vld <= 1'b1;
         end else begin
            last_pc_vld <= 1'b0;
         end
      end
   end

   // FIFO pointers and occupancy; full push with simultaneous pop keeps the level
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Dropped-record bookkeeping: sticky overflow and saturating drop counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (push_drop) begin
         overflow <= 1'b1;
         if (drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

   // Record storage; contents need no reset because the read port is gated by rd_valid
   always_ff @(posedge clk) begin
      if (push_ok) begin
         pc_mem[wr_ptr] <= pc_in;
         a_mem[wr_ptr]  <= reg_a_in;
         t_mem[wr_ptr]  <= reg_t_in;
      end
   end

   // Head record presented combinationally, zero while the FIFO is empty
   always_comb begin
      rd_pc = '0;
      rd_a  = '0;
      rd_t  = '0;
      if (rd_valid) begin
         rd_pc = pc_mem[rd_ptr];
         rd_a  = a_mem[rd_ptr];
         rd_t  = t_mem[rd_ptr];
      end
   end

`ifdef TOY_TRACE_TSTAMP_EN
   logic [TS_W-1:0] ts_cnt;
   logic [TS_W-1:0] ts_mem [DEPTH];

   // Free-running cycle counter, wraps naturally
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ts_cnt <= '0;
      end else begin
         ts_cnt <= ts_cnt + 1'b1;
      end
   end

   // Stamp storage alongside each record, holding the count at the sampling edge
   always_ff @(posedge clk) begin
      if (push_ok) begin
         ts_mem[wr_ptr] <= ts_cnt;
      end
   end

   // Head stamp, zero while empty
   always_comb begin
      rd_tstamp = '0;
      if (rd_valid) begin
         rd_tstamp = ts_mem[rd_ptr];
      end
   end
`else
   assign rd_tstamp = '0;
`endif

endmodule

// File: tb/tb_toy_trace_capture.sv
// Directed self-checking bench for toy_trace_capture (default parameters).
module tb_toy_trace_capture;

   logic        clk;
   logic        reset;
   logic [11:0] pc_in;
   logic [15:0] reg_a_in;
   logic [15:0] reg_t_in;
   logic        trace_en;
   logic        rd_ready;
   logic        rd_valid;
   logic [11:0] rd_pc;
   logic [15:0] rd_a;
   logic [15:0] rd_t;
   logic [15:0] rd_tstamp;
   logic [4:0]  level;
   logic        overflow;
   logic [7:0]  drop_cnt;
   logic        halted;

   int n_compared;
   int n_mismatched;

   toy_trace_capture #(.DEPTH(16), .HALT_CYCLES(8), .TS_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .pc_in     (pc_in),
      .reg_a_in  (reg_a_in),
      .reg_t_in  (reg_t_in),
      .trace_en  (trace_en),
      .rd_ready  (rd_ready),
      .rd_valid  (rd_valid),
      .rd_pc     (rd_pc),
      .rd_a      (rd_a),
      .rd_t      (rd_t),
      .rd_tstamp (rd_tstamp),
      .level     (level),
      .overflow  (overflow),
      .drop_cnt  (drop_cnt),
      .halted    (halted)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge, then settle 1 ns past it
   task automatic applyStimulus();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      assert (obs === exp)
      else begin
         n_mismatched++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] ts_exp;
      n_compared   = 0;
      n_mismatched = 0;
      reset    = 1'b0;
      trace_en = 1'b0;
      rd_ready = 1'b0;
      pc_in    = '0;
      reg_a_in = '0;
      reg_t_in = '0;
      applyStimulus();
      applyStimulus();
      checkOutput("rst_valid", 32'(rd_valid), 32'd0);
      checkOutput("rst_level", 32'(level), 32'd0);
      checkOutput("rst_halted", 32'(halted), 32'd0);
      checkOutput("rst_drop", 32'(drop_cnt), 32'd0);

      // Timestamp: five idle edges after release, record sampled when counter is 5
      reset = 1'b1;
      for (int i = 0; i < 5; i++) applyStimulus();
      trace_en = 1'b1;
      pc_in    = 12'h100;
      reg_a_in = 16'hBEEF;
      applyStimulus();
`ifdef TOY_TRACE_TSTAMP_EN
      ts_exp = 32'd5;
`else
      ts_exp = 32'd0;
`endif
      checkOutput("ts_level", 32'(level), 32'd1);
      checkOutput("ts_pc", 32'(rd_pc), 32'h100);
      checkOutput("ts_stamp", 32'(rd_tstamp), ts_exp);
      trace_en = 1'b0;
      rd_ready = 1'b1;
      applyStimulus();
      checkOutput("ts_drained", 32'(level), 32'd0);
      rd_ready = 1'b0;

      // Basic capture of three PCs then ordered drain
      trace_en = 1'b1;
      reg_a_in = 16'h1234;
      pc_in = 12'h010; reg_t_in = 16'h0A01; applyStimulus();
      pc_in = 12'h011; reg_t_in = 16'h0A02; applyStimulus();
      pc_in = 12'h012; reg_t_in = 16'h0A03; applyStimulus();
      trace_en = 1'b0;
      checkOutput("basic_level", 32'(level), 32'd3);
      checkOutput("basic_head_pc", 32'(rd_pc), 32'h010);
      checkOutput("basic_head_a", 32'(rd_a), 32'h1234);
      checkOutput("basic_head_t", 32'(rd_t), 32'h0A01);
      rd_ready = 1'b1;
      applyStimulus();
      checkOutput("basic_pop1_pc", 32'(rd_pc), 32'h011);
      applyStimulus();
      checkOutput("basic_pop2_pc", 32'(rd_pc), 32'h012);
      checkOutput("basic_pop2_t", 32'(rd_t), 32'h0A03);
      applyStimulus();
      checkOutput("basic_empty", 32'(rd_valid), 32'd0);
      checkOutput("basic_empty_pc", 32'(rd_pc), 32'd0);
      applyStimulus();
      checkOutput("basic_ready_empty", 32'(level), 32'd0);
      rd_ready = 1'b0;

      // Enable gap with unchanged PC records once more after re-enable
      trace_en = 1'b1;
      pc_in = 12'h020;
      applyStimulus();
      applyStimulus();
      checkOutput("gap_level1", 32'(level), 32'd1);
      trace_en = 1'b0;
      applyStimulus();
      applyStimulus();
      trace_en = 1'b1;
      applyStimulus();
      trace_en = 1'b0;
      checkOutput("gap_level2", 32'(level), 32'd2);
      rd_ready = 1'b1;
      applyStimulus();
      checkOutput("gap_second_pc", 32'(rd_pc), 32'h020);
      applyStimulus();
      checkOutput("gap_drained", 32'(level), 32'd0);

      // Halt: rises after the 8th repeated edge, stays set after PC moves on
      trace_en = 1'b1;
      pc_in = 12'h0FF;
      applyStimulus();
      for (int i = 0; i < 7; i++) applyStimulus();
      checkOutput("halt_after7", 32'(halted), 32'd0);
      applyStimulus();
      checkOutput("halt_after8", 32'(halted), 32'd1);
      pc_in = 12'h101;
      applyStimulus();
      checkOutput("halt_sticky", 32'(halted), 32'd1);
      trace_en = 1'b0;
      applyStimulus();
      applyStimulus();
      checkOutput("halt_drained", 32'(level), 32'd0);
      rd_ready = 1'b0;

      // Overflow: 20 distinct PCs into 16 entries, then push+pop while full
      checkOutput("ovf_clear_before", 32'(overflow), 32'd0);
      trace_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         pc_in = 12'h200 + 12'(i);
         applyStimulus();
      end
      checkOutput("ovf_level", 32'(level), 32'd16);
      checkOutput("ovf_flag", 32'(overflow), 32'd1);
      checkOutput("ovf_drop_cnt", 32'(drop_cnt), 32'd4);
      checkOutput("ovf_head", 32'(rd_pc), 32'h200);
      rd_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         pc_in = 12'h300 + 12'(i);
         applyStimulus();
      end
      checkOutput("full_pp_level", 32'(level), 32'd16);
      checkOutput("full_pp_drop", 32'(drop_cnt), 32'd4);
      checkOutput("full_pp_head", 32'(rd_pc), 32'h205);
      trace_en = 1'b0;
      rd_ready = 1'b0;

      // Asynchronous reset mid-cycle while full clears everything at once
      #2;
      reset = 1'b0;
      #1;
      checkOutput("arst_level", 32'(level), 32'd0);
      checkOutput("arst_valid", 32'(rd_valid), 32'd0);
      checkOutput("arst_pc", 32'(rd_pc), 32'd0);
      checkOutput("arst_a", 32'(rd_a), 32'd0);
      checkOutput("arst_ovf", 32'(overflow), 32'd0);
      checkOutput("arst_drop", 32'(drop_cnt), 32'd0);
      checkOutput("arst_halted", 32'(halted), 32'd0);
      applyStimulus();
      reset = 1'b1;
      applyStimulus();

      // First record after reset lands normally
      trace_en = 1'b1;
      pc_in    = 12'h3AB;
      reg_a_in = 16'h5555;
      applyStimulus();
      trace_en = 1'b0;
      checkOutput("post_rst_level", 32'(level), 32'd1);
      checkOutput("post_rst_a", 32'(rd_a), 32'h5555);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
